// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, busy scoreboard and registered debug tap
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  any_busy
);
  localparam int NUM_REGS = 2**ADDR_W;
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_mp: NRD must be in 1..4");
  end
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   dbg_q, dbg_d;
  logic                v0, v1, vs;
  assign v0 = we0 && (wa0 != '0 || ZERO_R0 == 0);
  assign v1 = we1 && (wa1 != '0 || ZERO_R0 == 0);
  assign vs = sb_set && (sb_addr != '0 || ZERO_R0 == 0);
  // next state: port 1 written last so it wins a same-address collision; sb_set applied after clears so it wins
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (v0) regs_d[wa0] = wd0;
    if (v1) regs_d[wa1] = wd1;
    if (v0) busy_d[wa0] = 1'b0;
    if (v1) busy_d[wa1] = 1'b0;
    if (vs) busy_d[sb_addr] = 1'b1;
    dbg_d = regs_d[dbg_addr];
  end
  // all state updates on the rising edge, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      dbg_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      dbg_q  <= dbg_d;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit0, hit1;
    assign a    = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit1 = BYPASS != 0 && v1 && wa1 == a;
    assign hit0 = BYPASS != 0 && v0 && wa0 == a;
    assign rd_data[k*DATA_W +: DATA_W] = (ZERO_R0 != 0 && a == '0) ? '0 : hit1 ? wd1 : hit0 ? wd0 : regs_q[a];
    assign rd_busy[k] = busy_q[a] & ~(hit0 | hit1);
  end
  assign dbg_data = dbg_q;
  assign any_busy = |busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp (default build plus ZERO_R0=0/BYPASS=0 build)
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_b;
  logic [1:0]  rd_busy, rd_busy_b;
  logic        we0, we1, sb_set;
  logic [4:0]  wa0, wa1, sb_addr, dbg_addr;
  logic [31:0] wd0, wd1, dbg_data, dbg_data_b;
  logic        any_busy, any_busy_b;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .sb_set(sb_set), .sb_addr(sb_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .any_busy(any_busy)
  );

  regfile_mp #(.ZERO_R0(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .sb_set(sb_set), .sb_addr(sb_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data_b), .any_busy(any_busy_b)
  );

  task automatic push(input string tag, input logic [63:0] exp);
    sb_q.push_back('{tag, exp});
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; sb_set = 0;
  endtask

  initial begin
    reset = 1; rd_addr = '0; dbg_addr = '0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; sb_addr = '0;
    idle();
    tick(); tick();
    reset = 0;
    // 1: fill everything, mark everything busy, then reset with a write still active
    for (int i = 0; i < 32; i++) begin
      we0 = 1; wa0 = 5'(i); wd0 = $urandom | 32'h1;
      sb_set = 1; sb_addr = 5'(i);
      tick();
    end
    we0 = 0; sb_set = 0;
    push("pre_reset_any_busy", 1);
    chk(any_busy);
    we0 = 1; wa0 = 5'd31; wd0 = 32'hFFFF_FFFF; sb_set = 1; sb_addr = 5'd31;
    reset = 1;
    tick();
    reset = 0;
    idle();
    for (int i = 0; i < 32; i += 2) begin
      rd_addr = {5'(i + 1), 5'(i)};
      push($sformatf("reset_rd_r%0d", i), 0);
      push($sformatf("reset_busy_r%0d", i), 0);
      #1;
      chk(rd_data);
      chk(rd_busy);
    end
    push("reset_dbg", 0);
    push("reset_any_busy", 0);
    push("reset_any_busy_b", 0);
    push("reset_dbg_b", 0);
    chk(dbg_data); chk(any_busy); chk(any_busy_b); chk(dbg_data_b);
    // 2: r0 writes and scoreboard sets
    we0 = 1; wa0 = 0; wd0 = 32'hDEADBEEF; sb_set = 1; sb_addr = 0; rd_addr = '0;
    push("r0_rd_same", 0);
    push("r0_busy_same", 0);
    push("r0_rd_b_same", 0);
    #1;
    chk(rd_data[31:0]); chk(rd_busy); chk(rd_data_b[31:0]);
    tick();
    idle();
    push("r0_rd_next", 0);
    push("r0_busy_next", 0);
    push("r0_any_busy", 0);
    push("r0_rd_b_next", 32'hDEADBEEF);
    push("r0_busy_b_next", 2'b11);
    #1;
    chk(rd_data[31:0]); chk(rd_busy); chk(any_busy); chk(rd_data_b[31:0]); chk(rd_busy_b);
    // 3: dual write collision
    we0 = 1; wa0 = 5; wd0 = 32'h1111_1111; we1 = 1; wa1 = 5; wd1 = 32'h2222_2222;
    rd_addr = {5'd5, 5'd5};
    push("coll_byp", {32'h2222_2222, 32'h2222_2222});
    #1;
    chk(rd_data);
    tick();
    idle();
    push("coll_stored", 32'h2222_2222);
    push("coll_stored_b", 32'h2222_2222);
    #1;
    chk(rd_data[31:0]); chk(rd_data_b[31:0]);
    // 4: bypass vs non-bypass, then two ports to distinct addresses
    we0 = 1; wa0 = 9; wd0 = 32'h0000_00AB; rd_addr = {5'd9, 5'd5};
    push("byp_r9", 32'h0000_00AB);
    push("nobyp_r9_old", 0);
    #1;
    chk(rd_data[63:32]); chk(rd_data_b[63:32]);
    tick();
    idle();
    push("nobyp_r9_next", 32'h0000_00AB);
    push("byp_r9_next", 32'h0000_00AB);
    #1;
    chk(rd_data_b[63:32]); chk(rd_data[63:32]);
    we0 = 1; wa0 = 10; wd0 = 32'hA0A0_0001; we1 = 1; wa1 = 11; wd1 = 32'hB0B0_0002;
    rd_addr = {5'd11, 5'd10};
    push("split_byp", {32'hB0B0_0002, 32'hA0A0_0001});
    #1;
    chk(rd_data);
    tick();
    idle();
    push("split_stored", {32'hB0B0_0002, 32'hA0A0_0001});
    #1;
    chk(rd_data_b);
    // 5: scoreboard
    sb_set = 1; sb_addr = 7; rd_addr = {5'd7, 5'd7};
    push("sb_no_byp_of_set", 0);
    push("sb_any_before", 0);
    #1;
    chk(rd_busy); chk(any_busy);
    tick();
    idle();
    push("sb_busy_r7", 2'b11);
    push("sb_any_after", 1);
    #1;
    chk(rd_busy); chk(any_busy);
    we0 = 1; wa0 = 7; wd0 = 32'h77; sb_set = 1; sb_addr = 7;
    push("sb_write_hides_busy", 0);
    push("sb_b_no_hide", 2'b11);
    #1;
    chk(rd_busy); chk(rd_busy_b);
    tick();
    idle();
    push("sb_set_wins", 2'b11);
    #1;
    chk(rd_busy);
    we1 = 1; wa1 = 7; wd1 = 32'h78;
    tick();
    idle();
    push("sb_cleared", 0);
    push("sb_any_cleared", 0);
    push("sb_rd_r7", 32'h78);
    #1;
    chk(rd_busy); chk(any_busy); chk(rd_data[31:0]);
    // 6: debug tap
    dbg_addr = 5;
    tick();
    push("dbg_r5", 32'h2222_2222);
    chk(dbg_data);
    dbg_addr = 31; we0 = 1; wa0 = 31; wd0 = 32'h0040_0010;
    push("dbg_before_edge", 32'h2222_2222);
    #1;
    chk(dbg_data);
    tick();
    idle();
    push("dbg_r31", 32'h0040_0010);
    chk(dbg_data);
    reset = 1;
    tick();
    reset = 0;
    push("dbg_after_reset", 0);
    push("r31_after_reset", 0);
    rd_addr = {5'd31, 5'd31};
    #1;
    chk(dbg_data); chk(rd_data[31:0]);
    if (sb_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
